// File: rtl/ssd_scan_n_pkg.sv
// ssd_scan_n_pkg -- shared constants and types for the multiplexed
// seven-segment scanner.
//   - active-low polarity constants for segments and digit enables
//   - segment codes for 0-F, blank and dash (bit 6 = g ... bit 0 = a)
//   - converter FSM state type and a hex-to-segment helper
package ssd_scan_n_pkg;

    // Both segments and digit enables are active-low on the board.
    localparam logic SEG_LIT  = 1'b0;
    localparam logic SEG_DARK = 1'b1;
    localparam logic SEL_ON   = 1'b0;
    localparam logic SEL_OFF  = 1'b1;

    localparam logic [6:0] SEG_BLANK = {7{SEG_DARK}};
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Indexed by nibble value: SEG_HEX[0] is '0', SEG_HEX[15] is 'F'.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Wide enough for the largest DIN plus the hex overflow shift (8 digits).
    localparam int PAD_W = 36;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_LOAD,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/bcd_dd_conv.sv
// bcd_dd_conv -- sequential double-dabble binary-to-BCD converter.
//   CLK, RST : clock, synchronous active-high reset (abandons any conversion)
//   start    : begin a conversion of bin (ignored while busy)
//   bin      : binary value, must be stable from start through the load cycle
//   busy     : conversion in progress (load, shift or done cycle)
//   done     : one-cycle pulse; bcd and ovf are valid in this cycle
//   bcd      : DIGITS packed BCD digits, digit 0 in bits [3:0]
//   ovf      : value did not fit in DIGITS decimal digits
// Timing: 1 load cycle, BIN_W shift cycles, then the done cycle.
module bcd_dd_conv #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);
    import ssd_scan_n_pkg::*;

    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_t           state, state_nxt;
    logic [BIN_W-1:0]      sh_q;
    logic [4*DIGITS-1:0]   acc_q;
    logic [4*DIGITS-1:0]   acc_adj;
    logic                  ovf_q;
    logic [CNT_W-1:0]      cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) state <= CONV_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt = state;
        case (state)
            CONV_IDLE:  if (start) state_nxt = CONV_LOAD;
            CONV_LOAD:  state_nxt = CONV_SHIFT;
            CONV_SHIFT: if (cnt_q == CNT_W'(BIN_W - 1)) state_nxt = CONV_DONE;
            CONV_DONE:  state_nxt = CONV_IDLE;
            default:    state_nxt = CONV_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != CONV_IDLE);
        done = (state == CONV_DONE);
    end

    // Add-3 correction on every BCD digit that is 5 or more before shifting.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    // A 1 leaving the top digit means the value needs a (DIGITS+1)-th digit;
    // it is made sticky because later shifts would lose it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sh_q  <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state)
                CONV_LOAD: begin
                    sh_q  <= bin;
                    acc_q <= '0;
                    ovf_q <= 1'b0;
                    cnt_q <= '0;
                end
                CONV_SHIFT: begin
                    acc_q <= {acc_adj[4*DIGITS-2:0], sh_q[BIN_W-1]};
                    sh_q  <= sh_q << 1;
                    ovf_q <= ovf_q | acc_adj[4*DIGITS-1];
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bcd = acc_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/ssd_scan_n.sv
// ssd_scan_n -- N-digit multiplexed seven-segment display driver.
//   CLK, RST : clock, synchronous active-high reset
//   DIN      : unsigned value, sampled once per frame
//   MODE     : 0 decimal, 1 hexadecimal (sampled with DIN)
//   BLANK_LZ : blank leading zeros (sampled with DIN)
//   DP       : per-digit decimal point request, active-high, sampled live
//   EN       : 0 turns all digits off; scanning and conversion continue
//   sel      : active-low one-hot digit enable
//   segs     : active-low segments g..a
//   dp_n     : active-low decimal point
//   OVF      : value of the last converted frame did not fit
module ssd_scan_n #(
    parameter int DIGITS   = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [BIN_W-1:0]  DIN,
    input  logic              MODE,
    input  logic              BLANK_LZ,
    input  logic [DIGITS-1:0] DP,
    input  logic              EN,
    output logic [DIGITS-1:0] sel,
    output logic [6:0]        segs,
    output logic              dp_n,
    output logic              OVF
);
    import ssd_scan_n_pkg::*;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]    div_q;
    logic [IDX_W-1:0]    idx_q, idx_nxt;
    logic                tick, frame_start;

    logic [BIN_W-1:0]    din_q;
    logic                mode_q, blz_q;

    logic                conv_busy, conv_done, conv_ovf;
    logic [4*DIGITS-1:0] conv_bcd;
    logic [PAD_W-1:0]    pad;
    logic                hex_ovf;

    // disp_* is written only on conversion done; show_* is the frame being
    // scanned out, refreshed at frame start so one frame never mixes two values.
    logic [4*DIGITS-1:0] disp_dig, show_dig, src_dig;
    logic                disp_ovf, show_ovf, src_ovf;
    logic                disp_blz, show_blz, src_blz;

    logic [DIGITS-1:0]   blank_mask;
    logic [3:0]          cur_nib;
    logic [6:0]          seg_nxt;

    assign tick        = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_start = tick && (idx_q == IDX_W'(DIGITS - 1));

    always_comb begin
        idx_nxt = idx_q;
        if (tick) idx_nxt = frame_start ? '0 : idx_q + IDX_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);
            idx_q <= idx_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            din_q  <= '0;
            mode_q <= 1'b0;
            blz_q  <= 1'b0;
        end else if (frame_start) begin
            din_q  <= DIN;
            mode_q <= MODE;
            blz_q  <= BLANK_LZ;
        end
    end

    bcd_dd_conv #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .CLK   (CLK),
        .RST   (RST),
        .start (frame_start && !conv_busy),
        .bin   (din_q),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // Hex path: nibbles straight from the sampled value; it follows the same
    // done pulse as the decimal path so both modes share one update point.
    assign pad     = PAD_W'(din_q);
    assign hex_ovf = |(pad >> (4 * DIGITS));

    always_ff @(posedge CLK) begin
        if (RST) begin
            disp_dig <= '0;
            disp_ovf <= 1'b0;
            disp_blz <= 1'b0;
            show_dig <= '0;
            show_ovf <= 1'b0;
            show_blz <= 1'b0;
        end else begin
            if (conv_done) begin
                disp_dig <= mode_q ? pad[4*DIGITS-1:0] : conv_bcd;
                disp_ovf <= mode_q ? hex_ovf : conv_ovf;
                disp_blz <= blz_q;
            end
            if (frame_start) begin
                show_dig <= disp_dig;
                show_ovf <= disp_ovf;
                show_blz <= disp_blz;
            end
        end
    end

    // Slot 0 is loaded on the same edge that refreshes show_*, so it must
    // read the incoming frame directly.
    always_comb begin
        src_dig = frame_start ? disp_dig : show_dig;
        src_ovf = frame_start ? disp_ovf : show_ovf;
        src_blz = frame_start ? disp_blz : show_blz;
    end

    // Walk from the top digit down; a digit is blank while every digit at or
    // above it is zero. Digit 0 always shows.
    always_comb begin
        logic lz_run;
        lz_run     = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run        = lz_run && (src_dig[4*i +: 4] == 4'd0);
            blank_mask[i] = src_blz && lz_run && (i != 0);
        end
    end

    always_comb begin
        cur_nib = src_dig[4*idx_nxt +: 4];
        if (src_ovf)                 seg_nxt = SEG_DASH;
        else if (blank_mask[idx_nxt]) seg_nxt = SEG_BLANK;
        else                         seg_nxt = seg_encode(cur_nib);
    end

    // Enable and data load on the same tick edge so they never skew.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel  <= {DIGITS{SEL_OFF}};
            segs <= SEG_BLANK;
            dp_n <= SEG_DARK;
        end else if (tick) begin
            sel  <= EN ? ~(DIGITS'(1) << idx_nxt) : {DIGITS{SEL_OFF}};
            segs <= seg_nxt;
            dp_n <= EN ? ~DP[idx_nxt] : SEG_DARK;
        end
    end

    assign OVF = disp_ovf;

endmodule

// File: tb/tb_ssd_scan_n.sv
// tb_ssd_scan_n -- scoreboard bench for ssd_scan_n (DIGITS=4, SCAN_DIV=20).
// Stimulus drives one value per frame (always mid-frame, in slot 2) and
// pushes the slot outputs it expects; a monitor pops one entry on every
// change of sel and compares sel, segs, dp_n and OVF.
module tb_ssd_scan_n;

    localparam int DIGITS   = 4;
    localparam int BIN_W    = 14;
    localparam int SCAN_DIV = 20;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000, SB = 7'b0000011, SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110, BL = 7'b1111111, DS = 7'b0111111;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [BIN_W-1:0]  DIN = '0;
    logic              MODE = 1'b0;
    logic              BLANK_LZ = 1'b0;
    logic [DIGITS-1:0] DP = 4'b0100;
    logic              EN = 1'b1;
    logic [DIGITS-1:0] sel;
    logic [6:0]        segs;
    logic              dp_n;
    logic              OVF;

    ssd_scan_n #(
        .DIGITS   (DIGITS),
        .BIN_W    (BIN_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DIN      (DIN),
        .MODE     (MODE),
        .BLANK_LZ (BLANK_LZ),
        .DP       (DP),
        .EN       (EN),
        .sel      (sel),
        .segs     (segs),
        .dp_n     (dp_n),
        .OVF      (OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] sel;
        logic [6:0] segs;
        logic       dp_n;
        logic       ovf;
    } slot_t;

    typedef struct {
        logic [BIN_W-1:0] din;
        logic             mode;
        logic             blz;
        logic [3:0][6:0]  seg;   // index = digit number
        logic             ovf;
    } vec_t;

    slot_t exp_q[$];
    vec_t  va[10];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    always @(posedge CLK) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(posedge CLK);
        #1;
    endtask

    task automatic push_slot(input int k, input logic [6:0] sg, input logic ovf);
        slot_t s;
        s.sel  = ~(4'b0001 << k);
        s.segs = sg;
        s.dp_n = ~DP[k];
        s.ovf  = ovf;
        exp_q.push_back(s);
    endtask

    // Vector j is driven in slot 2 of the frame before frame j, sampled at
    // the start of frame j and shown during frame j+1. OVF follows the
    // conversion, so slots 1..3 of frame j already report vector j.
    task automatic run_frames(input int first, input int n);
        logic [3:0][6:0] prev_seg;
        logic            prev_ovf;
        int              vi;
        prev_seg = {S0, S0, S0, S0};
        prev_ovf = 1'b0;
        for (int k = 1; k < DIGITS; k++) push_slot(k, S0, 1'b0);
        for (int j = 0; j <= n; j++) begin
            wait_cyc(FRAME * j + 45);
            vi = first + ((j < n) ? j : n - 1);
            DIN      = va[vi].din;
            MODE     = va[vi].mode;
            BLANK_LZ = va[vi].blz;
            push_slot(0, prev_seg[0], prev_ovf);
            for (int k = 1; k < DIGITS; k++) push_slot(k, prev_seg[k], va[vi].ovf);
            prev_seg = va[vi].seg;
            prev_ovf = va[vi].ovf;
        end
        wait_cyc(FRAME * (n + 1) + 62);
        check("queue drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sel"},  sel,  4'b1111);
        check({tag, " segs"}, segs, 7'h7F);
        check({tag, " dp_n"}, dp_n, 1'b1);
        check({tag, " OVF"},  OVF,  1'b0);
    endtask

    // Monitor: one expected entry per sel change; idle while reset is held.
    logic [3:0] prev_sel = 4'b1111;
    slot_t      got_exp;
    always @(negedge CLK) begin
        if (RST) begin
            prev_sel = sel;
        end else if (sel !== prev_sel) begin
            prev_sel = sel;
            if (exp_q.size() > 0) begin
                got_exp = exp_q.pop_front();
                check("slot sel",  sel,  got_exp.sel);
                check("slot segs", segs, got_exp.segs);
                check("slot dp_n", dp_n, got_exp.dp_n);
                check("slot OVF",  OVF,  got_exp.ovf);
            end
        end
    end

    initial begin
        va[0] = '{din: 14'd1234,  mode: 1'b0, blz: 1'b0, seg: {S1, S2, S3, S4}, ovf: 1'b0};
        va[1] = '{din: 14'd7,     mode: 1'b0, blz: 1'b1, seg: {BL, BL, BL, S7}, ovf: 1'b0};
        va[2] = '{din: 14'd0,     mode: 1'b0, blz: 1'b1, seg: {BL, BL, BL, S0}, ovf: 1'b0};
        va[3] = '{din: 14'h2BEF,  mode: 1'b1, blz: 1'b0, seg: {S2, SB, SE, SF}, ovf: 1'b0};
        va[4] = '{din: 14'd10000, mode: 1'b0, blz: 1'b0, seg: {DS, DS, DS, DS}, ovf: 1'b1};
        va[5] = '{din: 14'd9999,  mode: 1'b0, blz: 1'b0, seg: {S9, S9, S9, S9}, ovf: 1'b0};
        va[6] = '{din: 14'd1234,  mode: 1'b0, blz: 1'b0, seg: {S1, S2, S3, S4}, ovf: 1'b0};
        va[7] = '{din: 14'd5678,  mode: 1'b0, blz: 1'b0, seg: {S5, S6, S7, S8}, ovf: 1'b0};
        va[8] = '{din: 14'd42,    mode: 1'b0, blz: 1'b1, seg: {BL, BL, S4, S2}, ovf: 1'b0};
        va[9] = va[8];

        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK) RST = 1'b0;

        run_frames(0, 8);

        // Overflowing value sampled at the next frame start, then reset
        // 3 cycles into its conversion: no done may ever surface.
        DIN = 14'd10000; MODE = 1'b0; BLANK_LZ = 1'b0;
        wait_cyc(FRAME * 10 + 3);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check_reset_outputs("mid-conv reset");
        @(posedge CLK);
        @(negedge CLK) RST = 1'b0;

        run_frames(8, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
